// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle main control FSM.
// Holds state encodings, opcodes, mux/ALU encodings and the decoded control vector.
// Pure declarations; no timing or flow-control behaviour of its own.
package ctrl_pkg;

  // FSM state encodings (4-bit, visible on the debug port)
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC      = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_ADDI_EXEC = 4'd8;
  localparam logic [3:0] S_ADDI_WB   = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [3:0] S_ILLEGAL   = 4'd12;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SB   = 6'h28;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // ALU operation class
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_BRANCH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Decoded datapath controls for one cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       byte_ops;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_decode.sv
// Next-state and control-vector decode for the multi-cycle control FSM.
// Latency: purely combinational, zero cycles.
// Backpressure: memReady stalls FETCH, MEM_READ and MEM_WRITE; ignored elsewhere.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [3:0]     state,
  input  logic [OPW-1:0] opcode,
  input  logic           memReady,
  output logic [3:0]     next_state,
  output ctrl_out_t      ctrl
);

  logic is_lb;
  logic is_lw;
  logic is_sb;
  logic is_sw;

  assign is_lb = (opcode == OP_LB);
  assign is_lw = (opcode == OP_LW);
  assign is_sb = (opcode == OP_SB);
  assign is_sw = (opcode == OP_SW);

  // Map (state, opcode, memReady) to next state and this cycle's controls
  always_comb begin
    next_state = state;
    ctrl       = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (memReady) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          next_state    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded
        ctrl.alu_src_b = ALUB_BRANCH;
        if (is_lb || is_lw || is_sb || is_sw) next_state = S_MEM_ADDR;
        else if (opcode == OP_R)              next_state = S_EXEC;
        else if (opcode == OP_ADDI)           next_state = S_ADDI_EXEC;
        else if (opcode == OP_BEQ)            next_state = S_BRANCH;
        else if (opcode == OP_J)              next_state = S_JUMP;
        else                                  next_state = S_ILLEGAL;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        if (is_lb || is_lw)      next_state = S_MEM_READ;
        else if (is_sb || is_sw) next_state = S_MEM_WRITE;
        else                     next_state = S_ILLEGAL;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.byte_ops = is_lb;
        if (memReady) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.byte_ops   = is_lb;
        next_state      = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.byte_ops  = is_sb;
        if (memReady) next_state = S_FETCH;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REG;
        ctrl.alu_op    = ALU_FUNCT;
        next_state     = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        next_state     = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next_state     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        next_state     = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        next_state         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        next_state     = S_FETCH;
      end
      // ILLEGAL and unused encodings 13-15 all park in ILLEGAL
      default: next_state = S_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style main control FSM; optional perf counters via CTRL_PERF_COUNT_EN.
// Latency: J/BEQ 3, R/ADDI/SW/SB 4, LW/LB 5 cycles, plus one per memory-wait cycle.
// Backpressure: holds in FETCH/MEM_READ/MEM_WRITE until memReady; reset forces all outputs to 0.
module multi_cycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           memReady,
  output logic           pcWrite,
  output logic           pcWriteCond,
  output logic           irWrite,
  output logic           memRead,
  output logic           memWrite,
  output logic           regWrite,
  output logic           byteOperations,
  output logic           regDst,
  output logic           memToReg,
  output logic           aluSrcA,
  output logic [1:0]     aluSrcB,
  output logic [1:0]     aluOp,
  output logic [1:0]     pcSource,
  output logic           illegalOp,
  output logic [3:0]     state
`ifdef CTRL_PERF_COUNT_EN
  ,
  output logic [31:0]    cycleCount,
  output logic [31:0]    instrCount
`endif
);

  logic [3:0] state_q;
  logic [3:0] next_state;
  logic       illegal_q;
  ctrl_out_t  ctrl;
  ctrl_out_t  ctrl_g;

  ctrl_decode #(.OPW(OPW)) u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .memReady   (memReady),
    .next_state (next_state),
    .ctrl       (ctrl)
  );

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= next_state;
      if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  // Reset masks every output so no PC increment or write leaks out during reset
  always_comb begin
    ctrl_g = ctrl;
    if (reset) ctrl_g = '0;
  end

  assign pcWrite        = ctrl_g.pc_write;
  assign pcWriteCond    = ctrl_g.pc_write_cond;
  assign irWrite        = ctrl_g.ir_write;
  assign memRead        = ctrl_g.mem_read;
  assign memWrite       = ctrl_g.mem_write;
  assign regWrite       = ctrl_g.reg_write;
  assign byteOperations = ctrl_g.byte_ops;
  assign regDst         = ctrl_g.reg_dst;
  assign memToReg       = ctrl_g.mem_to_reg;
  assign aluSrcA        = ctrl_g.alu_src_a;
  assign aluSrcB        = ctrl_g.alu_src_b;
  assign aluOp          = ctrl_g.alu_op;
  assign pcSource       = ctrl_g.pc_source;
  assign illegalOp      = illegal_q & ~reset;
  assign state          = reset ? S_FETCH : state_q;

`ifdef CTRL_PERF_COUNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instr_q;

  // Cycle counter runs outside ILLEGAL; instruction counter ticks on each return to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      if (state_q < S_ILLEGAL) cycle_q <= cycle_q + 32'd1;
      if ((state_q != S_FETCH) && (next_state == S_FETCH)) instr_q <= instr_q + 32'd1;
    end
  end

  assign cycleCount = reset ? 32'd0 : cycle_q;
  assign instrCount = reset ? 32'd0 : instr_q;
`endif

endmodule
